// File: rtl/rr_mux_arb_pkg.sv
// rr_mux_pkg: arbitration mode constants and the rotating-priority pick helper
// shared by the arbiter. The helper works on a fixed 16-bit vector (the channel
// count ceiling); callers zero-extend their channel vectors into it.
package rr_mux_pkg;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;
   localparam int MAX_CH    = 16;

   // First set bit of valid at or above ptr, wrapping modulo n; one-hot or zero.
   function automatic logic [MAX_CH-1:0] rr_pick(input logic [MAX_CH-1:0] valid,
                                                  input logic [3:0]        ptr,
                                                  input logic [4:0]        n);
      logic [MAX_CH-1:0] g;
      logic              found;
      logic [4:0]        idx;
      g     = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_CH; i++) begin
         idx = {1'b0, ptr} + 5'(i);
         if (idx >= n) idx = idx - n;
         if ((5'(i) < n) && !found && valid[idx[3:0]]) begin
            g[idx[3:0]] = 1'b1;
            found       = 1'b1;
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/rr_mux_arb_if.sv
// rr_mux_arb_if: N_CH producer channels plus one registered output stage.
// master = producer/consumer side (testbench or surrounding logic),
// slave  = the arbitrating mux itself.
interface rr_mux_arb_if #(
   parameter  int N_CH   = 4,
   parameter  int DATA_W = 8,
   localparam int SEL_W  = $clog2(N_CH)
);
   logic [N_CH*DATA_W-1:0] in_data;
   logic [N_CH-1:0]        in_valid;
   logic [N_CH-1:0]        in_last;
   logic [N_CH-1:0]        in_ready;
   logic [DATA_W-1:0]      out_data;
   logic [SEL_W-1:0]       out_sel;
   logic                   out_last;
   logic                   out_valid;
   logic                   out_ready;

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_sel, out_last, out_valid
   );

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_sel, out_last, out_valid
   );
endinterface

// File: rtl/rr_mux_arb_arbiter.sv
// rr_arbiter: grant logic plus round-robin pointer and optional packet lock.
// Define RR_MUX_PKT_LOCK_EN to keep a channel granted until its last beat.
module rr_arbiter
   import rr_mux_pkg::*;
#(
   parameter  int N_CH     = 4,
   parameter  int ARB_MODE = ARB_RR,
   localparam int SEL_W    = $clog2(N_CH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_CH-1:0]  valid,
   input  logic [N_CH-1:0]  last,
   input  logic             take,     // a beat moved from gnt_idx this cycle
   output logic [N_CH-1:0]  gnt,
   output logic [SEL_W-1:0] gnt_idx
);

   logic [SEL_W-1:0]  rr_ptr;
   logic [N_CH-1:0]   elig;
   logic              adv;
   logic [MAX_CH-1:0] elig_w;
   logic [MAX_CH-1:0] pick_w;
   logic [3:0]        ptr_w;
   logic              unused_pick;

`ifdef RR_MUX_PKT_LOCK_EN
   logic             lock;
   logic [SEL_W-1:0] lock_ch;

   // while a packet is open only its channel may compete
   always_comb begin
      elig = valid;
      if (lock) elig = valid & (N_CH'(1) << lock_ch);
   end

   // pointer moves only once the packet is complete
   assign adv = take && last[gnt_idx];

   // open a packet on a non-last beat, close it on the last beat
   always_ff @(posedge clk) begin
      if (rst) begin
         lock    <= 1'b0;
         lock_ch <= '0;
      end else if (take) begin
         lock    <= !last[gnt_idx];
         lock_ch <= gnt_idx;
      end
   end
`else
   logic unused_last;
   assign unused_last = ^last;
   assign elig        = valid;
   assign adv         = take;
`endif

   // rotating (or fixed, ptr pinned to 0) pick over eligible channels
   always_comb begin
      elig_w              = '0;
      elig_w[N_CH-1:0]    = elig;
      ptr_w               = '0;
      if (ARB_MODE == ARB_RR) ptr_w[SEL_W-1:0] = rr_ptr;
      pick_w              = rr_pick(elig_w, ptr_w, 5'(N_CH));
      gnt                 = pick_w[N_CH-1:0];
   end
   assign unused_pick = &{1'b0, pick_w};

   // one-hot grant to channel index
   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < N_CH; i++)
         if (gnt[i]) gnt_idx = SEL_W'(i);
   end

   // next search starts just past the channel that was served
   always_ff @(posedge clk) begin
      if (rst)
         rr_ptr <= '0;
      else if ((ARB_MODE == ARB_RR) && adv)
         rr_ptr <= (gnt_idx == SEL_W'(N_CH-1)) ? '0 : gnt_idx + 1'b1;
   end

endmodule

// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N-channel arbitrated mux with a registered valid/ready output.
// Optional packet lock is enabled by defining RR_MUX_PKT_LOCK_EN.
module rr_mux_arb
   import rr_mux_pkg::*;
#(
   parameter  int N_CH     = 4,
   parameter  int DATA_W   = 8,
   parameter  int ARB_MODE = ARB_RR,
   localparam int SEL_W    = $clog2(N_CH)
) (
   input  logic         clk,
   input  logic         rst,
   rr_mux_arb_if.slave  bus
);

   logic             load;
   logic             take;
   logic [N_CH-1:0]  gnt;
   logic [SEL_W-1:0] gnt_idx;

   // output register can accept when empty or being drained; nothing during reset
   assign load         = !rst && (!bus.out_valid || bus.out_ready);
   assign bus.in_ready = load ? gnt : '0;
   assign take         = |(bus.in_valid & bus.in_ready);

   rr_arbiter #(
      .N_CH     (N_CH),
      .ARB_MODE (ARB_MODE)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .valid   (bus.in_valid),
      .last    (bus.in_last),
      .take    (take),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // output stage: reload on transfer, drop valid on an empty load, else hold
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_sel   <= '0;
         bus.out_last  <= 1'b0;
      end else if (load) begin
         if (take) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= bus.in_data[gnt_idx*DATA_W +: DATA_W];
            bus.out_sel   <= gnt_idx;
            bus.out_last  <= bus.in_last[gnt_idx];
         end else begin
            bus.out_valid <= 1'b0;
         end
      end
   end

endmodule
